// File: rtl/decode_stage.sv
// Instruction decode: splits fields, reads two operands from an 8x16 register file, sign-extends imm7.
// Latency: 1 clock; every output is registered at the ID/EX boundary.
// Backpressure: none; the stage decodes the presented instruction on every clock edge.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instruction,
    input  logic        regWrite,
    input  logic [2:0]  writeReg,
    input  logic [15:0] writeData,
    output logic [2:0]  opCode,
    output logic [15:0] readData1,
    output logic [15:0] readData2,
    output logic [15:0] signExtend,
    output logic [2:0]  rt,
    output logic [2:0]  rd
);

    // Register file; entry 0 is never written so it always reads as zero.
    logic [15:0] regFile [8];

    logic [2:0]  rsIdx;
    logic [2:0]  rtIdx;
    logic [2:0]  rdIdx;
    logic [2:0]  opIdx;
    logic [15:0] immExt;
    logic        wrValid;
    logic [15:0] operandA;
    logic [15:0] operandB;

    assign opIdx   = instruction[15:13];
    assign rsIdx   = instruction[12:10];
    assign rtIdx   = instruction[9:7];
    assign rdIdx   = instruction[6:4];
    assign immExt  = {{9{instruction[6]}}, instruction[6:0]};
    assign wrValid = regWrite && (writeReg != 3'd0);

    // Operand select: R0 reads zero, a same-edge write to the source register is forwarded.
    always_comb begin
        operandA = regFile[rsIdx];
        operandB = regFile[rtIdx];
        if (rsIdx == 3'd0) begin
            operandA = 16'h0000;
        end else if (wrValid && (writeReg == rsIdx)) begin
            operandA = writeData;
        end
        if (rtIdx == 3'd0) begin
            operandB = 16'h0000;
        end else if (wrValid && (writeReg == rtIdx)) begin
            operandB = writeData;
        end
    end

    // Write-back port; held off while reset is asserted, R0 writes dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regFile[i] <= 16'h0000;
            end
        end else if (wrValid) begin
            regFile[writeReg] <= writeData;
        end
    end

    // ID/EX pipeline register capturing the decoded fields and operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCode     <= 3'd0;
            readData1  <= 16'h0000;
            readData2  <= 16'h0000;
            signExtend <= 16'h0000;
            rt         <= 3'd0;
            rd         <= 3'd0;
        end else begin
            opCode     <= opIdx;
            readData1  <= operandA;
            readData2  <= operandB;
            signExtend <= immExt;
            rt         <= rtIdx;
            rd         <= rdIdx;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: reset, directed vector table, same-edge bypass, R0 protection, random traffic.
// Expected outputs are queued when stimulus is driven and checked one edge later.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruction;
    logic        regWrite;
    logic [2:0]  writeReg;
    logic [15:0] writeData;
    logic [2:0]  opCode;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic [15:0] signExtend;
    logic [2:0]  rt;
    logic [2:0]  rd;

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .opCode     (opCode),
        .readData1  (readData1),
        .readData2  (readData2),
        .signExtend (signExtend),
        .rt         (rt),
        .rd         (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] se;
        logic [2:0]  rt;
        logic [2:0]  rd;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic        we;
        logic [2:0]  wr;
        logic [15:0] wd;
        exp_t        exp;
    } vec_t;

    exp_t        sbq[$];
    vec_t        table_v[$];
    logic [15:0] mR [8];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s vector %0d: got %h expected %h", name, vectors, act, req);
        end
    endtask

    task automatic checkOutputs(input exp_t e);
        vectors++;
        checkField("opCode",     {13'd0, opCode}, {13'd0, e.op});
        checkField("readData1",  readData1,       e.d1);
        checkField("readData2",  readData2,       e.d2);
        checkField("signExtend", signExtend,      e.se);
        checkField("rt",         {13'd0, rt},     {13'd0, e.rt});
        checkField("rd",         {13'd0, rd},     {13'd0, e.rd});
    endtask

    task automatic popAndCheck();
        exp_t e;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: output produced with no expectation queued");
        end else begin
            e = sbq.pop_front();
            checkOutputs(e);
        end
    endtask

    // Independent reference: field split, R0 zero, write-through bypass.
    function automatic exp_t modelExp(input logic [15:0] ins, input logic we,
                                      input logic [2:0] wr, input logic [15:0] wd);
        exp_t        e;
        logic [2:0]  s;
        logic [2:0]  t;
        s = ins[12:10];
        t = ins[9:7];
        e.op = ins[15:13];
        e.rt = t;
        e.rd = ins[6:4];
        e.se = ins[6] ? (16'hFF80 | {9'd0, ins[6:0]}) : {9'd0, ins[6:0]};
        e.d1 = (s == 3'd0) ? 16'h0000 : ((we && wr == s) ? wd : mR[s]);
        e.d2 = (t == 3'd0) ? 16'h0000 : ((we && wr == t) ? wd : mR[t]);
        return e;
    endfunction

    // Called on a falling edge: drive, queue expectation, check after the rising edge.
    task automatic applyVec(input logic [15:0] ins, input logic we, input logic [2:0] wr,
                            input logic [15:0] wd, input exp_t e);
        instruction = ins;
        regWrite    = we;
        writeReg    = wr;
        writeData   = wd;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        popAndCheck();
        if (we && wr != 3'd0) mR[wr] = wd;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [15:0] ins, input logic we, input logic [2:0] wr,
                                input logic [15:0] wd, input logic [2:0] op, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] se, input logic [2:0] t,
                                input logic [2:0] d);
        vec_t v;
        v.instr = ins; v.we = we; v.wr = wr; v.wd = wd;
        v.exp.op = op; v.exp.d1 = d1; v.exp.d2 = d2; v.exp.se = se; v.exp.rt = t; v.exp.rd = d;
        return v;
    endfunction

    initial begin
        exp_t zeroE;
        exp_t e;
        zeroE = '{op: 3'd0, d1: 16'h0, d2: 16'h0, se: 16'h0, rt: 3'd0, rd: 3'd0};
        for (int i = 0; i < 8; i++) mR[i] = 16'h0000;

        // Directed table, applied in order from a freshly reset register file.
        table_v.push_back(mk(16'h0C00, 0, 3'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0)); // R3 write in reset blocked
        table_v.push_back(mk(16'h1234, 0, 3'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0034, 3'd4, 3'd3));
        table_v.push_back(mk(16'hFEDC, 1, 3'd4, 16'hABCD, 3'd7, 16'h0000, 16'h0000, 16'hFFDC, 3'd5, 3'd5));
        table_v.push_back(mk(16'h1234, 0, 3'd0, 16'h0000, 3'd0, 16'hABCD, 16'hABCD, 16'h0034, 3'd4, 3'd3));
        table_v.push_back(mk(16'h1234, 1, 3'd4, 16'h5555, 3'd0, 16'h5555, 16'h5555, 16'h0034, 3'd4, 3'd3)); // bypass both
        table_v.push_back(mk(16'h1234, 0, 3'd0, 16'h0000, 3'd0, 16'h5555, 16'h5555, 16'h0034, 3'd4, 3'd3));
        table_v.push_back(mk(16'h0000, 1, 3'd0, 16'hFFFF, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0)); // R0 write
        table_v.push_back(mk(16'h0000, 0, 3'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0));
        table_v.push_back(mk(16'hFEDC, 1, 3'd5, 16'h1111, 3'd7, 16'h0000, 16'h1111, 16'hFFDC, 3'd5, 3'd5)); // bypass rt only
        table_v.push_back(mk(16'hFEDC, 1, 3'd7, 16'h7777, 3'd7, 16'h7777, 16'h1111, 16'hFFDC, 3'd5, 3'd5)); // bypass rs only
        table_v.push_back(mk(16'h578F, 0, 3'd0, 16'h0000, 3'd2, 16'h1111, 16'h7777, 16'h000F, 3'd7, 3'd0));
        table_v.push_back(mk(16'h0040, 0, 3'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'hFFC0, 3'd0, 3'd4)); // imm sign boundary
        table_v.push_back(mk(16'h003F, 0, 3'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h003F, 3'd0, 3'd3));

        // Reset held with clocks running and a write attempted: outputs stay zero.
        rst_n       = 1'b0;
        instruction = 16'hFEDC;
        regWrite    = 1'b1;
        writeReg    = 3'd3;
        writeData   = 16'h1234;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutputs(zeroE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyVec(16'hFEDC, 1'b0, 3'd0, 16'h0000,
                 '{op: 3'd7, d1: 16'h0, d2: 16'h0, se: 16'hFFDC, rt: 3'd5, rd: 3'd5});

        foreach (table_v[i])
            applyVec(table_v[i].instr, table_v[i].we, table_v[i].wr, table_v[i].wd, table_v[i].exp);

        // Instruction change between edges must not disturb the registered outputs.
        e = '{op: 3'd0, d1: 16'h0000, d2: 16'h0000, se: 16'h003F, rt: 3'd0, rd: 3'd3};
        applyVec(16'h003F, 1'b0, 3'd0, 16'h0000, e);
        instruction = 16'hFEDC;
        #2;
        checkOutputs(e);

        // Random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] ins;
            logic        we;
            logic [2:0]  wr;
            logic [15:0] wd;
            ins = 16'($urandom);
            we  = 1'($urandom);
            wr  = (i % 4 == 0) ? ins[12:10] : 3'($urandom);
            wd  = 16'($urandom);
            applyVec(ins, we, wr, wd, modelExp(ins, we, wr, wd));
        end

        // Asynchronous reset mid-cycle clears outputs immediately and the register file.
        instruction = 16'h578F;
        regWrite    = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutputs(zeroE);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mR[i] = 16'h0000;
        applyVec(16'h578F, 1'b0, 3'd0, 16'h0000,
                 '{op: 3'd2, d1: 16'h0, d2: 16'h0, se: 16'h000F, rt: 3'd7, rd: 3'd0});

        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
